bus_read_arbiter: RTL and testbench



---
 rtl/bus_read_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bus_read_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_read_arbiter.sv
// bus_read_arbiter
// Registered read-data arbiter for the DSP external 16-bit bus. Each
// qualified read passes IDLE -> SETTLE -> DRIVE. At the end of SETTLE the
// block samples the source avail flags, picks one source, and latches its
// data. It then drives output_enable/db_drive for the top-level tri-state
// until read_qualified drops.
//
// Optional build macro: BUS_ARB_ROUND_ROBIN_EN
//   defined : rotating priority. The search starts just after the last
//             granted index, and grant_id holds its value on a miss.
//   absent  : fixed priority, lowest index wins, and a miss reports 7.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | bus released, waiting for read_qualified
// SETTLE | one cycle for sources to settle; sample/grant at its end
// DRIVE  | output_enable=1, latched data held until read ends

module bus_read_arbiter #(
  parameter int          N_SRC        = 8,
  parameter logic [15:0] DEFAULT_DATA = 16'h3333
) (
  input  logic                 xclk,
  input  logic                 reset,
  input  logic                 read_qualified,
  input  logic [N_SRC-1:0]     src_avail,
  input  logic [16*N_SRC-1:0]  src_data,
  input  logic                 cnt_clear,
  output logic                 output_enable,
  output logic [15:0]          db_drive,
  output logic [2:0]           grant_id,
  output logic [7:0]           collision_cnt,
  output logic [7:0]           miss_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DRIVE  = 2'd2
  } state_t;

  localparam logic [N_SRC-1:0] AVAIL_ONE = N_SRC'(1);
  localparam logic [7:0]       CNT_MAX   = 8'hFF;

  state_t              state;
  state_t              state_nxt;
  logic                sample_en;

  logic                win_found;
  logic [2:0]          win_idx;
  logic [15:0]         win_data;
  logic                any_avail;
  logic                multi_avail;

  // State register; a low reset forces IDLE on the next edge, even mid-read.
  always_ff @(posedge xclk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and outputs. The grant is taken only on SETTLE -> DRIVE, so a
  // read abandoned during SETTLE leaves no trace.
  always_comb begin
    state_nxt     = state;
    sample_en     = 1'b0;
    output_enable = 1'b0;
    case (state)
      IDLE: begin
        if (read_qualified) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (read_qualified) begin
          state_nxt = DRIVE;
          sample_en = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      DRIVE: begin
        output_enable = 1'b1;
        if (!read_qualified) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pick the winning source from the live avail flags.
  // Round-robin runs two passes: indices above the last grant first, then
  // wrap to the rest. This is a search starting at (last + 1) mod N_SRC,
  // done without a modulo.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_data  = DEFAULT_DATA;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < N_SRC; i++) begin
      if (!win_found && src_avail[i] && (i > int'(grant_id))) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_data  = src_data[16*i +: 16];
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!win_found && src_avail[i] && (i <= int'(grant_id))) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_data  = src_data[16*i +: 16];
      end
    end
`else
    for (int i = 0; i < N_SRC; i++) begin
      if (!win_found && src_avail[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_data  = src_data[16*i +: 16];
      end
    end
`endif
  end

  // Contention detect. Clearing the lowest set bit leaves a non-zero value
  // only if at least two flags are set.
  always_comb begin
    any_avail   = |src_avail;
    multi_avail = |(src_avail & (src_avail - AVAIL_ONE));
  end

  // Latched read data and grant; both change only on SETTLE -> DRIVE, so they
  // stay constant through DRIVE whatever the sources do.
  always_ff @(posedge xclk) begin
    if (!reset) begin
      db_drive <= 16'h0000;
      grant_id <= 3'd0;
    end else if (sample_en) begin
      db_drive <= win_data;
      if (win_found) begin
        grant_id <= win_idx;
      end else begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
        grant_id <= grant_id;
`else
        grant_id <= 3'd7;
`endif
      end
    end
  end

  // Diagnostic counters: saturating, and clear wins over a same-cycle increment.
  always_ff @(posedge xclk) begin
    if (!reset) begin
      collision_cnt <= 8'h00;
      miss_cnt      <= 8'h00;
    end else if (cnt_clear) begin
      collision_cnt <= 8'h00;
      miss_cnt      <= 8'h00;
    end else if (sample_en) begin
      if (multi_avail && (collision_cnt != CNT_MAX)) begin
        collision_cnt <= collision_cnt + 8'd1;
      end
      if (!any_avail && (miss_cnt != CNT_MAX)) begin
        miss_cnt <= miss_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_read_arbiter.sv
// Self-checking bench for bus_read_arbiter. A behavioural model computes the
// grant, latched data and counters for each read directly from the read
// rules. Each test task compares the DUT's outputs with that model.

module tb_bus_read_arbiter;

  localparam int          N_SRC        = 8;
  localparam logic [15:0] DEFAULT_DATA = 16'h3333;

  logic         xclk;
  logic         reset;
  logic         read_qualified;
  logic [7:0]   src_avail;
  logic [127:0] src_data;
  logic         cnt_clear;
  logic         output_enable;
  logic [15:0]  db_drive;
  logic [2:0]   grant_id;
  logic [7:0]   collision_cnt;
  logic [7:0]   miss_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int          m_coll;
  int          m_miss;
  logic [15:0] m_db;
  logic [2:0]  m_grant;

  bus_read_arbiter #(.N_SRC(N_SRC), .DEFAULT_DATA(DEFAULT_DATA)) dut (
    .xclk           (xclk),
    .reset          (reset),
    .read_qualified (read_qualified),
    .src_avail      (src_avail),
    .src_data       (src_data),
    .cnt_clear      (cnt_clear),
    .output_enable  (output_enable),
    .db_drive       (db_drive),
    .grant_id       (grant_id),
    .collision_cnt  (collision_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  task automatic tick();
    @(posedge xclk);
    #1;
  endtask

  function automatic logic [35:0] obs();
    return {output_enable, db_drive, grant_id, collision_cnt, miss_cnt};
  endfunction

  function automatic logic [35:0] expv(input logic oe);
    return {oe, m_db, m_grant, 8'(m_coll), 8'(m_miss)};
  endfunction

  function automatic logic [127:0] rand_data();
    logic [127:0] d;
    for (int i = 0; i < N_SRC; i++) d[16*i +: 16] = 16'($urandom);
    return d;
  endfunction

  function automatic void model_reset();
    m_coll  = 0;
    m_miss  = 0;
    m_db    = 16'h0000;
    m_grant = 3'd0;
  endfunction

  // one completed read, as seen at the sampling edge
  function automatic void model_read(input logic [7:0] avail, input logic [127:0] data,
                                     input bit clr);
    int n_set  = $countones(avail);
    int winner = -1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N_SRC; k++) begin
      int idx = (int'(m_grant) + k) % N_SRC;
      if (winner < 0 && avail[idx]) winner = idx;
    end
`else
    for (int i = 0; i < N_SRC; i++) begin
      if (winner < 0 && avail[i]) winner = i;
    end
`endif
    if (winner < 0) begin
      m_db = DEFAULT_DATA;
`ifndef BUS_ARB_ROUND_ROBIN_EN
      m_grant = 3'd7;
`endif
    end else begin
      m_db    = data[16*winner +: 16];
      m_grant = 3'(winner);
    end
    if (clr) begin
      m_coll = 0;
      m_miss = 0;
    end else begin
      if (n_set == 0) m_miss = (m_miss >= 255) ? 255 : m_miss + 1;
      if (n_set >= 2) m_coll = (m_coll >= 255) ? 255 : m_coll + 1;
    end
  endfunction

  // Stimulus only: runs IDLE -> SETTLE -> DRIVE and leaves the DUT in DRIVE.
  task automatic start_read(input logic [7:0] avail, input logic [127:0] data, input bit clr);
    read_qualified = 1'b1;
    src_avail      = avail;
    src_data       = data;
    cnt_clear      = 1'b0;
    tick();
    cnt_clear = clr;
    tick();
    cnt_clear = 1'b0;
    model_read(avail, data, clr);
  endtask

  task automatic end_read();
    read_qualified = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    read_qualified = 1'b1;
    src_avail      = 8'hFF;
    src_data       = rand_data();
    cnt_clear      = 1'b0;
    tick();
    tick();
    model_reset();
    n_cmp++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs(), expv(1'b0));
    end
    read_qualified = 1'b0;
    reset          = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", obs(), expv(1'b0));
    end
  endtask

  task automatic test_single();
    logic [127:0] d = rand_data();
    d[32 +: 16]    = 16'hA5A5;
    read_qualified = 1'b1;
    src_avail      = 8'b0000_0100;
    src_data       = d;
    tick();
    n_cmp++;
    if (output_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_settle_oe: got %b expected 0", output_enable);
    end
    tick();
    model_read(8'b0000_0100, d, 1'b0);
    n_cmp++;
    if (obs() !== expv(1'b1)) begin
      n_fail++;
      $display("FAIL single_drive: got %h expected %h", obs(), expv(1'b1));
    end
    end_read();
    n_cmp++;
    if (output_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release_oe: got %b expected 0", output_enable);
    end
  endtask

  task automatic test_collision();
    logic [127:0] d = rand_data();
    for (int r = 0; r < 2; r++) begin
      start_read(8'b1000_0010, d, 1'b0);
      n_cmp++;
      if (obs() !== expv(1'b1)) begin
        n_fail++;
        $display("FAIL collision_read%0d: got %h expected %h", r, obs(), expv(1'b1));
      end
      end_read();
    end
  endtask

  task automatic test_miss();
    start_read(8'h00, rand_data(), 1'b0);
    n_cmp++;
    if (obs() !== expv(1'b1)) begin
      n_fail++;
      $display("FAIL miss_read: got %h expected %h", obs(), expv(1'b1));
    end
    end_read();
  endtask

  task automatic test_hold();
    start_read(8'b0001_0000, rand_data(), 1'b0);
    for (int c = 0; c < 3; c++) begin
      src_data  = rand_data();
      src_avail = 8'($urandom);
      tick();
      n_cmp++;
      if (obs() !== expv(1'b1)) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got %h expected %h", c, obs(), expv(1'b1));
      end
    end
    end_read();
    n_cmp++;
    if (output_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release_oe: got %b expected 0", output_enable);
    end
    start_read(8'b0001_0000, rand_data(), 1'b0);
    n_cmp++;
    if (obs() !== expv(1'b1)) begin
      n_fail++;
      $display("FAIL hold_resample: got %h expected %h", obs(), expv(1'b1));
    end
    end_read();
  endtask

  task automatic test_back_to_back();
    logic [7:0] pats [3] = '{8'b0100_0000, 8'b0000_0011, 8'b0010_1000};
    for (int r = 0; r < 3; r++) begin
      start_read(pats[r], rand_data(), 1'b0);
      n_cmp++;
      if (obs() !== expv(1'b1)) begin
        n_fail++;
        $display("FAIL b2b_read%0d: got %h expected %h", r, obs(), expv(1'b1));
      end
      end_read();
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int r = 0; r < 40; r++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      start_read(a, rand_data(), 1'b0);
      n_cmp++;
      if (obs() !== expv(1'b1)) begin
        n_fail++;
        $display("FAIL random_read%0d avail=%b: got %h expected %h", r, a, obs(), expv(1'b1));
      end
      end_read();
      n_cmp++;
      if (output_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL random_release%0d: got %b expected 0", r, output_enable);
      end
    end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 300; r++) begin
      start_read(8'b0000_0011 | 8'($urandom), rand_data(), 1'b0);
      end_read();
    end
    n_cmp++;
    if (collision_cnt !== 8'hFF || obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL collision_saturate: got %h expected %h", obs(), expv(1'b0));
    end
    start_read(8'b0000_0110, rand_data(), 1'b1);
    n_cmp++;
    if (collision_cnt !== 8'h00 || obs() !== expv(1'b1)) begin
      n_fail++;
      $display("FAIL clear_precedence: got %h expected %h", obs(), expv(1'b1));
    end
    end_read();
  endtask

  task automatic test_abort_settle();
    start_read(8'h00, rand_data(), 1'b0);
    end_read();
    read_qualified = 1'b1;
    src_avail      = 8'b0000_0011;
    src_data       = rand_data();
    tick();
    read_qualified = 1'b0;
    tick();
    n_cmp++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL abort_settle: got %h expected %h", obs(), expv(1'b0));
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (output_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_settle_oe%0d: got %b expected 0", c, output_enable);
      end
    end
  endtask

  task automatic test_abort_reset();
    start_read(8'b1100_0000, rand_data(), 1'b0);
    reset = 1'b0;
    tick();
    model_reset();
    n_cmp++;
    if (obs() !== expv(1'b0)) begin
      n_fail++;
      $display("FAIL abort_reset: got %h expected %h", obs(), expv(1'b0));
    end
    read_qualified = 1'b0;
    reset          = 1'b1;
    tick();
    start_read(8'b0000_1001, rand_data(), 1'b0);
    n_cmp++;
    if (obs() !== expv(1'b1)) begin
      n_fail++;
      $display("FAIL after_reset_read: got %h expected %h", obs(), expv(1'b1));
    end
    end_read();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_collision();
    test_miss();
    test_hold();
    test_back_to_back();
    test_random();
    test_saturate();
    test_abort_settle();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
